// File: rtl/cnn_frame_sequencer.sv
// cnn_frame_sequencer
//   Frame-level controller for the MNIST CNN pipeline. On start it holds the
//   pipeline in reset for FLUSH_CYCLES cycles. It then streams PIXELS pixels
//   from pixel memory into conv1, one pixel per cycle. Next it waits for the
//   comparator result, latches the decision and pulses done. Between frames
//   the pipeline is held in reset.
//
//   Ports
//     clk, rst_n        clock (rising edge), asynchronous active-low reset
//     start             frame request, sampled only in IDLE
//     busy / done       high in FLUSH/STREAM/WAIT / 1-cycle frame-end pulse
//     mem_rd_en         pixel memory read strobe
//     mem_addr          pixel address 0..PIXELS-1
//     mem_rdata         pixel data for the address issued in the current cycle
//     pipe_rst_n        active-low reset to all pipeline stages
//     pix_out           pixel to conv1
//     pix_valid         pix_out carries a frame pixel
//     res_valid_in      comparator valid
//     res_decision_in   comparator decision
//     decision          latched class (4'hF on timeout)
//     decision_valid    decision is valid, held until next start
//     timeout           last frame aborted, held until next start
//
//   Optional feature: define CNN_SEQ_TIMEOUT_EN to abort WAIT after
//   TIMEOUT_CYCLES cycles without a result. Without the macro, WAIT waits
//   indefinitely and timeout is tied low.
module cnn_frame_sequencer #(
   parameter int unsigned PIXELS         = 784,
   parameter int unsigned ADDR_W         = 10,
   parameter int unsigned FLUSH_CYCLES   = 2,
   parameter int unsigned TIMEOUT_CYCLES = 4096,
   parameter int unsigned TO_W           = 13
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [7:0]        mem_rdata,
   output logic              pipe_rst_n,
   output logic [7:0]        pix_out,
   output logic              pix_valid,
   input  logic              res_valid_in,
   input  logic [3:0]        res_decision_in,
   output logic [3:0]        decision,
   output logic              decision_valid,
   output logic              timeout
);

   localparam int unsigned       FL_W       = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam logic [FL_W-1:0]   FLUSH_LAST = FL_W'(FLUSH_CYCLES - 1);
   localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(PIXELS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FLUSH,
      S_STREAM,
      S_WAIT,
      S_DONE
   } state_e;

   state_e            state_q, state_d;
   logic [FL_W-1:0]   flush_cnt_q, flush_cnt_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              mem_rd_en_q, mem_rd_en_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic              pipe_rst_n_q, pipe_rst_n_d;
   logic [7:0]        pix_out_q, pix_out_d;
   logic              pix_valid_q, pix_valid_d;
   logic [3:0]        decision_q, decision_d;
   logic              decision_valid_q, decision_valid_d;

`ifdef CNN_SEQ_TIMEOUT_EN
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
   logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
   logic              timeout_q, timeout_d;
`else
   logic              unused_timeout_cfg;
   assign unused_timeout_cfg = ^TO_W'(TIMEOUT_CYCLES);
`endif

   always_comb begin
      state_d          = state_q;
      flush_cnt_d      = flush_cnt_q;
      mem_addr_d       = mem_addr_q;
      decision_d       = decision_q;
      decision_valid_d = decision_valid_q;
`ifdef CNN_SEQ_TIMEOUT_EN
      to_cnt_d         = to_cnt_q;
      timeout_d        = timeout_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d          = S_FLUSH;
               flush_cnt_d      = '0;
               decision_d       = '0;
               decision_valid_d = 1'b0;
`ifdef CNN_SEQ_TIMEOUT_EN
               timeout_d        = 1'b0;
`endif
            end
         end
         S_FLUSH: begin
            if (flush_cnt_q == FLUSH_LAST) begin
               state_d    = S_STREAM;
               mem_addr_d = '0;
            end else begin
               flush_cnt_d = flush_cnt_q + 1'b1;
            end
         end
         S_STREAM: begin
            if (mem_addr_q == ADDR_LAST) begin
               state_d    = S_WAIT;
               mem_addr_d = '0;
`ifdef CNN_SEQ_TIMEOUT_EN
               to_cnt_d   = '0;
`endif
            end else begin
               mem_addr_d = mem_addr_q + 1'b1;
            end
         end
         S_WAIT: begin
            // A result arriving in the expiry cycle takes priority over the abort.
            if (res_valid_in) begin
               state_d          = S_DONE;
               decision_d       = res_decision_in;
               decision_valid_d = 1'b1;
            end
`ifdef CNN_SEQ_TIMEOUT_EN
            else if (to_cnt_q == TO_LAST) begin
               state_d    = S_DONE;
               decision_d = 4'hF;
               timeout_d  = 1'b1;
            end else begin
               to_cnt_d = to_cnt_q + 1'b1;
            end
`endif
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Control outputs are registered from the next state so they line up with it.
      busy_d       = (state_d == S_FLUSH) || (state_d == S_STREAM) || (state_d == S_WAIT);
      done_d       = (state_d == S_DONE);
      mem_rd_en_d  = (state_d == S_STREAM);
      // Released one cycle after streaming begins, together with the first pixel.
      pipe_rst_n_d = (state_q == S_STREAM) || (state_q == S_WAIT);
      pix_valid_d  = mem_rd_en_q;
      pix_out_d    = mem_rd_en_q ? mem_rdata : 8'h00;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q          <= S_IDLE;
         flush_cnt_q      <= '0;
         busy_q           <= 1'b0;
         done_q           <= 1'b0;
         mem_rd_en_q      <= 1'b0;
         mem_addr_q       <= '0;
         pipe_rst_n_q     <= 1'b0;
         pix_out_q        <= '0;
         pix_valid_q      <= 1'b0;
         decision_q       <= '0;
         decision_valid_q <= 1'b0;
`ifdef CNN_SEQ_TIMEOUT_EN
         to_cnt_q         <= '0;
         timeout_q        <= 1'b0;
`endif
      end else begin
         state_q          <= state_d;
         flush_cnt_q      <= flush_cnt_d;
         busy_q           <= busy_d;
         done_q           <= done_d;
         mem_rd_en_q      <= mem_rd_en_d;
         mem_addr_q       <= mem_addr_d;
         pipe_rst_n_q     <= pipe_rst_n_d;
         pix_out_q        <= pix_out_d;
         pix_valid_q      <= pix_valid_d;
         decision_q       <= decision_d;
         decision_valid_q <= decision_valid_d;
`ifdef CNN_SEQ_TIMEOUT_EN
         to_cnt_q         <= to_cnt_d;
         timeout_q        <= timeout_d;
`endif
      end
   end

   assign busy           = busy_q;
   assign done           = done_q;
   assign mem_rd_en      = mem_rd_en_q;
   assign mem_addr       = mem_addr_q;
   assign pipe_rst_n     = pipe_rst_n_q;
   assign pix_out        = pix_out_q;
   assign pix_valid      = pix_valid_q;
   assign decision       = decision_q;
   assign decision_valid = decision_valid_q;
`ifdef CNN_SEQ_TIMEOUT_EN
   assign timeout        = timeout_q;
`else
   assign timeout        = 1'b0;
`endif

endmodule

// File: tb/tb_cnn_frame_sequencer.sv
module tb_cnn_frame_sequencer;

   localparam int unsigned PIXELS         = 784;
   localparam int unsigned ADDR_W         = 10;
   localparam int unsigned FLUSH_CYCLES   = 2;
   localparam int unsigned TIMEOUT_CYCLES = 64;
`ifdef CNN_SEQ_TIMEOUT_EN
   localparam int RES_DELAY = 40;
`else
   localparam int RES_DELAY = 500;
`endif

   logic              clk = 1'b0;
   logic              rst_n;
   logic              start;
   logic              busy, done, mem_rd_en, pipe_rst_n, pix_valid;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_rdata, pix_out;
   logic              res_valid_in;
   logic [3:0]        res_decision_in, decision;
   logic              decision_valid, timeout;
   logic [28:0]       outs;

   int vectors = 0;
   int errors  = 0;

   always #5 clk = ~clk;

   // Pixel memory model: the pixel at address a is a[7:0], available for
   // the address presented during the current cycle.
   assign mem_rdata = mem_addr[7:0];

   // Every output resets to zero, so the packed bundle has a zero reset value.
   assign outs = {busy, done, mem_rd_en, mem_addr, pipe_rst_n, pix_out, pix_valid,
                  decision, decision_valid, timeout};

   cnn_frame_sequencer #(
      .PIXELS(PIXELS),
      .ADDR_W(ADDR_W),
      .FLUSH_CYCLES(FLUSH_CYCLES),
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
      .TO_W(13)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .start(start),
      .busy(busy),
      .done(done),
      .mem_rd_en(mem_rd_en),
      .mem_addr(mem_addr),
      .mem_rdata(mem_rdata),
      .pipe_rst_n(pipe_rst_n),
      .pix_out(pix_out),
      .pix_valid(pix_valid),
      .res_valid_in(res_valid_in),
      .res_decision_in(res_decision_in),
      .decision(decision),
      .decision_valid(decision_valid),
      .timeout(timeout)
   );

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   // Pulses start and checks the first cycle after the edge that sampled it.
   task automatic begin_frame(input string tag);
      start = 1'b1;
      step();
      start = 1'b0;
      vectors++;
      if ({busy, pipe_rst_n, decision_valid, timeout} !== 4'b1000)
         $display("FAIL %s_start: busy/pipe_rst_n/dvalid/timeout got %b expected 1000", tag,
                  {busy, pipe_rst_n, decision_valid, timeout});
   endtask

   // Entered right after the edge that sampled start (edge 0). Observes FLUSH
   // and STREAM and checks them against the expected timing and pixel values.
   // With stop_at > 0 it returns once that many pixels have been seen.
   task automatic run_stream(input string tag, input bit noise, input int stop_at);
      int         n = 0;
      int         first_rst = -1;
      int         first_rd = -1;
      int         rd_cnt = 0;
      int         pix_cnt = 0;
      int         last_edge = -1;
      bit         gap = 1'b0;
      bit         busy_drop = 1'b0;
      bit         early = 1'b0;
      logic [7:0] exp_pix;
      logic [7:0] last_pix = 8'h00;
      while (n < 3000) begin
         if (noise && busy && (mem_rd_en || !pipe_rst_n)) begin
            res_valid_in    = 1'($urandom_range(0, 1));
            res_decision_in = 4'($urandom_range(0, 15));
         end else begin
            res_valid_in = 1'b0;
         end
         step();
         n++;
         if (busy !== 1'b1) busy_drop = 1'b1;
         if (pipe_rst_n === 1'b1 && first_rst < 0) first_rst = n;
         if (mem_rd_en === 1'b1) begin
            if (first_rd < 0) first_rd = n;
            vectors++;
            if (mem_addr !== ADDR_W'(rd_cnt))
               $display("FAIL %s_addr: got %0d expected %0d", tag, mem_addr, rd_cnt);
            rd_cnt++;
         end
         if (pix_valid === 1'b1) begin
            exp_pix = 8'(pix_cnt % 256);
            vectors++;
            if (pix_out !== exp_pix)
               $display("FAIL %s_pixel[%0d]: got %02h expected %02h", tag, pix_cnt, pix_out, exp_pix);
            if (pix_cnt > 0 && last_edge != n - 1) gap = 1'b1;
            last_edge = n;
            last_pix  = pix_out;
            pix_cnt++;
         end
         if (stop_at > 0 && pix_cnt >= stop_at) begin
            early = 1'b1;
            break;
         end
         if (pix_cnt > 0 && pix_valid !== 1'b1) break;
      end
      res_valid_in = 1'b0;
      vectors++;
      if (n >= 3000) begin
         errors++;
         $display("FAIL %s_bound: frame did not finish within %0d cycles", tag, n);
      end else if (!early) begin
         vectors++;
         if (first_rst != int'(FLUSH_CYCLES) + 1) begin
            errors++;
            $display("FAIL %s_pipe_rst_rise: got edge %0d expected %0d", tag, first_rst, FLUSH_CYCLES + 1);
         end
         vectors++;
         if (first_rd != int'(FLUSH_CYCLES)) begin
            errors++;
            $display("FAIL %s_first_rd: got edge %0d expected %0d", tag, first_rd, FLUSH_CYCLES);
         end
         vectors++;
         if (pix_cnt != int'(PIXELS) || rd_cnt != int'(PIXELS)) begin
            errors++;
            $display("FAIL %s_count: got pix %0d reads %0d expected %0d", tag, pix_cnt, rd_cnt, PIXELS);
         end
         vectors++;
         if (gap || busy_drop) begin
            errors++;
            $display("FAIL %s_continuity: got gap %0d busy_drop %0d expected 0 0", tag, gap, busy_drop);
         end
         vectors++;
         if (last_pix !== 8'h0F) begin
            errors++;
            $display("FAIL %s_last_pixel: got %02h expected 0f", tag, last_pix);
         end
         vectors++;
         if ({mem_rd_en, mem_addr, pix_out, pipe_rst_n} !== {1'b0, ADDR_W'(0), 8'h00, 1'b1}) begin
            errors++;
            $display("FAIL %s_wait_outputs: rd %b addr %0d pix %02h prst %b expected 0 0 00 1", tag,
                     mem_rd_en, mem_addr, pix_out, pipe_rst_n);
         end
      end
   endtask

   // Entered in the second WAIT cycle. Delivers a result after 'delay'
   // cycles and checks the latch, the done pulse and the return to IDLE.
   task automatic finish_frame(input string tag, input int delay, input logic [3:0] d, input bit hold);
      bit bad = 1'b0;
      for (int i = 1; i < delay; i++) begin
         start = hold ? 1'b1 : 1'($urandom_range(0, 1));
         step();
         if ({busy, done, decision_valid} !== 3'b100) bad = 1'b1;
      end
      vectors++;
      if (bad) begin
         errors++;
         $display("FAIL %s_wait_hold: busy/done/dvalid left 100 before result", tag);
      end
      start           = hold;
      res_valid_in    = 1'b1;
      res_decision_in = d;
      step();
      vectors++;
      if ({decision, decision_valid, done, busy, timeout} !== {d, 4'b1100}) begin
         errors++;
         $display("FAIL %s_result: dec/dv/done/busy/to got %h %b%b%b%b expected %h 1100", tag,
                  decision, decision_valid, done, busy, timeout, d);
      end
      // Start and a second result during DONE must both be ignored.
      start           = 1'b1;
      res_decision_in = d ^ 4'h5;
      step();
      res_valid_in = 1'b0;
      vectors++;
      if ({decision, decision_valid, done, busy} !== {d, 3'b100}) begin
         errors++;
         $display("FAIL %s_idle: dec/dv/done/busy got %h %b%b%b expected %h 100", tag,
                  decision, decision_valid, done, busy, d);
      end
      start = hold;
      if (!hold) begin
         step();
         vectors++;
         if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL %s_no_queue: busy/done got %b expected 00", tag, {busy, done});
         end
      end
   endtask

   task automatic test_reset;
      rst_n           = 1'b0;
      start           = 1'b0;
      res_valid_in    = 1'b0;
      res_decision_in = 4'h0;
      repeat (3) step();
      vectors++;
      if (outs !== '0) begin
         errors++;
         $display("FAIL reset_values: got %h expected 0", outs);
      end
      rst_n = 1'b1;
      for (int i = 0; i < 100; i++) begin
         res_valid_in    = 1'($urandom_range(0, 1));
         res_decision_in = 4'($urandom_range(0, 15));
         step();
         vectors++;
         if ({pipe_rst_n, busy, mem_rd_en, done, decision_valid} !== 5'b00000) begin
            errors++;
            $display("FAIL idle_hold[%0d]: prst/busy/rd/done/dv got %b expected 00000", i,
                     {pipe_rst_n, busy, mem_rd_en, done, decision_valid});
         end
      end
      res_valid_in = 1'b0;
   endtask

   task automatic test_frame;
      begin_frame("frame");
      run_stream("frame", 1'b0, 0);
      finish_frame("frame", RES_DELAY, 4'd2, 1'b0);
   endtask

   task automatic test_back_to_back;
      logic [3:0] d;
      start = 1'b1;
      step();
      for (int f = 0; f < 2; f++) begin
         vectors++;
         if ({busy, decision_valid} !== 2'b10) begin
            errors++;
            $display("FAIL b2b_restart[%0d]: busy/dv got %b expected 10", f, {busy, decision_valid});
         end
         run_stream("b2b", 1'b1, 0);
         d = 4'($urandom_range(0, 9));
         finish_frame("b2b", 20 + int'($urandom_range(0, 30)), d, 1'b1);
         if (f == 1) start = 1'b0;
         step();
      end
      vectors++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL b2b_stop: busy got %b expected 0", busy);
      end
   endtask

   task automatic test_async_reset;
      bit saw_done = 1'b0;
      begin_frame("arst");
      run_stream("arst", 1'b0, 400);
      #2;
      rst_n = 1'b0;
      #1;
      vectors++;
      if (outs !== '0) begin
         errors++;
         $display("FAIL arst_immediate: got %h expected 0", outs);
      end
      repeat (2) begin
         step();
         if (done !== 1'b0) saw_done = 1'b1;
      end
      rst_n = 1'b1;
      repeat (3) begin
         step();
         if (done !== 1'b0) saw_done = 1'b1;
      end
      vectors++;
      if (saw_done || busy !== 1'b0) begin
         errors++;
         $display("FAIL arst_idle: done_seen %0d busy %b expected 0 0", saw_done, busy);
      end
      begin_frame("arst_new");
      run_stream("arst_new", 1'b0, 0);
      finish_frame("arst_new", 30, 4'($urandom_range(0, 9)), 1'b0);
   endtask

`ifdef CNN_SEQ_TIMEOUT_EN
   task automatic test_timeout;
      bit bad = 1'b0;
      begin_frame("tmo");
      run_stream("tmo", 1'b0, 0);
      // run_stream returns one edge after WAIT is entered.
      for (int i = 1; i < int'(TIMEOUT_CYCLES) - 1; i++) begin
         step();
         if ({done, timeout} !== 2'b00) bad = 1'b1;
      end
      vectors++;
      if (bad) begin
         errors++;
         $display("FAIL tmo_early: done/timeout rose before expiry");
      end
      step();
      vectors++;
      if ({timeout, decision, decision_valid, done, busy} !== {1'b1, 4'hF, 3'b010}) begin
         errors++;
         $display("FAIL tmo_abort: to/dec/dv/done/busy got %b %h %b%b%b expected 1 f 010",
                  timeout, decision, decision_valid, done, busy);
      end
      step();
      vectors++;
      if ({timeout, done} !== 2'b10) begin
         errors++;
         $display("FAIL tmo_hold: to/done got %b expected 10", {timeout, done});
      end
      // A result in the expiry cycle wins over the abort.
      begin_frame("tmo_tie");
      run_stream("tmo_tie", 1'b0, 0);
      repeat (int'(TIMEOUT_CYCLES) - 2) step();
      res_valid_in    = 1'b1;
      res_decision_in = 4'd7;
      step();
      res_valid_in = 1'b0;
      vectors++;
      if ({timeout, decision, decision_valid, done} !== {1'b0, 4'd7, 2'b11}) begin
         errors++;
         $display("FAIL tmo_tie: to/dec/dv/done got %b %h %b%b expected 0 7 11",
                  timeout, decision, decision_valid, done);
      end
      step();
   endtask
`endif

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_frame();
      test_back_to_back();
      test_async_reset();
`ifdef CNN_SEQ_TIMEOUT_EN
      test_timeout();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
